// File: rtl/writeback_queue.sv
// writeback_queue: in-order pending-write FIFO feeding the register-file write port, with rs/rt forwarding
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  output logic                     wb_ready,
  input  logic                     drain_en,
  output logic                     regWrite,
  output logic [4:0]               rd,
  output logic [31:0]              writeData,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [31:0]              fwd1_data,
  output logic [31:0]              fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] Full = (AW+1)'(DEPTH);
  logic [4:0]    rdMem   [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          push, pop;
  assign wb_ready  = count != Full;
  assign push      = wb_valid && wb_ready && wb_rd != 5'd0;
  assign regWrite  = count != '0 && drain_en;
  assign pop       = regWrite;
  assign rd        = count != '0 ? rdMem[rdPtr] : 5'd0;
  assign writeData = count != '0 ? dataMem[rdPtr] : 32'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rdMem[wrPtr]   <= wb_rd;
      dataMem[wrPtr] <= wb_data;
    end
  end
  // Walk oldest to youngest so the last match is the youngest
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = 32'd0;
    fwd2_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < count && rs != 5'd0 && rdMem[rdPtr + AW'(i)] == rs) begin
        fwd1_hit  = 1'b1;
        fwd1_data = dataMem[rdPtr + AW'(i)];
      end
      if ((AW+1)'(i) < count && rt != 5'd0 && rdMem[rdPtr + AW'(i)] == rt) begin
        fwd2_hit  = 1'b1;
        fwd2_data = dataMem[rdPtr + AW'(i)];
      end
    end
  end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of pending-write entries (power of two, 2 to 16).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port wb_valid  input  1  writeback request present.
REQ-005 The block SHALL have port wb_rd  input  5  destination register of the request.
REQ-006 The block SHALL have port wb_data  input  32  value to write.
REQ-007 The block SHALL have port wb_ready  output  1  queue can accept a request this cycle.
REQ-008 The block SHALL have port drain_en  input  1  register-file write port available this cycle.
REQ-009 The block SHALL have port regWrite  output  1  register-file write enable.
REQ-010 The block SHALL have port rd  output  5  register-file write address.
REQ-011 The block SHALL have port writeData  output  32  register-file write data.
REQ-012 The block SHALL have ports rs and rt  input  5 each  register-file read addresses to snoop.
REQ-013 The block SHALL have ports fwd1_hit and fwd2_hit  output  1 each  pending write matches rs or rt respectively.
REQ-014 The block SHALL have ports fwd1_data and fwd2_data  output  32 each  forwarded value for rs or rt.
REQ-015 The block SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 The block SHALL be a FIFO of {rd, data} entries that feeds the register-file write port in arrival order.
REQ-017 wb_ready SHALL equal (count != DEPTH), with no pop-through at full.
REQ-018 A request SHALL be accepted on a rising edge where wb_valid && wb_ready.
REQ-019 An accepted request with wb_rd == 0 SHALL be discarded without storing it or changing count, because register 0 is hardwired zero.
REQ-020 regWrite SHALL be combinational and equal (count != 0) && drain_en.
REQ-021 rd and writeData SHALL show the head entry when count != 0 and SHALL be 0 when empty.
REQ-022 The head entry SHALL be popped on each rising edge where regWrite == 1; the register file captures it on that same edge.
REQ-023 Latency: a request accepted at edge N SHALL appear at the head no earlier than the cycle after edge N, with no same-cycle bypass from wb_* to rd/writeData.
REQ-024 On simultaneous accept and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 fwd1_hit SHALL be 1 when rs != 0 and any valid entry has rd == rs; fwd1_data SHALL be the data of the youngest such entry, else 0.
REQ-027 fwd2_hit and fwd2_data SHALL behave identically for rt.
REQ-028 Forwarding SHALL consider stored entries only (not the wb_* inputs in the same cycle) and SHALL include the head entry even in its pop cycle.
REQ-029 When wb_valid is high while wb_ready is low, the block SHALL ignore the request and leave state unchanged; the source holds the request.

Reset
REQ-030 While rst_n == 0, pointers and count SHALL be 0 and regWrite, rd, writeData, wb_ready-gated state, fwd*_hit and fwd*_data SHALL be 0; wb_ready SHALL be 1 once count is 0.
REQ-031 Reset asserted mid-operation SHALL discard all pending entries immediately (asynchronously), and no register-file write SHALL occur after assertion.
REQ-032 Storage contents need not be reset; outputs SHALL depend on them only through valid entries.

Verification
REQ-033 Basic: drain_en=1; push {rd=1, data=9} -> next cycle regWrite=1, rd=1, writeData=9, then count returns to 0.
REQ-034 Full/back-pressure: drain_en=0; push {1,10},{2,20},{3,30},{4,40} -> count=4, wb_ready=0; a 5th push is ignored; drain_en=1 -> writes r1..r4 in order over 4 cycles.
REQ-035 Zero register: push {rd=0, data=5} -> count stays 0 and regWrite never asserts.
REQ-036 Forwarding: drain_en=0; push {5,100} then {5,200}; rs=5, rt=6 -> fwd1_hit=1, fwd1_data=200, fwd2_hit=0, fwd2_data=0; rs=0 -> fwd1_hit=0.
REQ-037 Simultaneous push/pop and wrap: drain_en=1 with a push every cycle for 10 cycles -> count stays 1 after the first cycle and all 10 writes leave in order across pointer wrap.
REQ-038 Async reset: drain_en=0, 3 entries pending, pulse rst_n low between edges -> count=0 and regWrite=0 immediately; after release, wb_ready=1 and no writes are issued.
